ram_rnw1_fwd: RTL and testbench
===============================

# ram_rnw1_fwd

Parametrised single-write, multi-read byte-enabled RAM for packet and descriptor buffering. It succeeds the plain one-read/one-write double-buffer RAM and adds:
- N independent read ports with selectable read latency and per-port valid flags.
- Write-to-read forwarding, so a read never returns stale data for a write accepted in an earlier cycle.
- A hardware clear engine that zeroes the array after reset or on request.

## Interface
Parameters:
- DATA_W, 512, word width in bits (multiple of 8)
- ADDR_W, 10, address width; depth = 2**ADDR_W
- EN_W, DATA_W/8, byte-enable width
- RD_PORTS, 2, number of read ports (1..4)
- RD_LAT, 1, read latency in cycles (1 or 2)
- CLR_ON_RST, 1, 1 = clear array after reset; 0 = ready immediately

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- clr_i  in  1  single-cycle pulse; starts a full array clear
- ready_o  out  1  array accepts accesses
- wr_en_i  in  1  write request
- wr_be_i  in  EN_W  byte enables
- wr_addr_i  in  ADDR_W  write address
- wr_data_i  in  DATA_W  write data
- rd_en_i  in  RD_PORTS  per-port read request
- rd_addr_i  in  RD_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data_o  out  RD_PORTS*DATA_W  packed read data
- rd_valid_o  out  RD_PORTS  per-port data valid

## Operation
- FSM states: CLEAR, READY.
- Reset with CLR_ON_RST=1 enters CLEAR with clr_cnt=0. Reset with CLR_ON_RST=0 enters READY.
- CLEAR writes all-zero data to address clr_cnt, all bytes, then increments clr_cnt. After address 2**ADDR_W-1 the FSM moves to READY. Clear takes exactly 2**ADDR_W cycles.
- clr_i sampled high in READY moves to CLEAR with clr_cnt=0. clr_i in CLEAR restarts the counter at 0.
- ready_o = (state==READY), registered.
- While ready_o is low, wr_en_i and rd_en_i are ignored and rd_valid_o stays 0. The pending write stage and the read pipelines are flushed when CLEAR is entered.
- Write path: one input register stage (wr_v, be, addr, data). In the following cycle, bytes with be=1 are committed to the array. Bytes with be=0 are untouched.
- Read path, per port: address sampled at the edge where rd_en_i[p]=1. Array word is merged with the write stage: if wr_v and the addresses match, each byte with be=1 takes the write-stage byte.
- Visibility: a write accepted at edge T is returned by any read sampled at edge T+1 or later. A read at the same edge T as the write to the same address returns the old data.
- All read ports may target the same address, including the write address, in the same cycle. Each returns identical data.
- rd_data_o[p] holds its last value when no new read completes.

## Timing
- Reset values: ready_o=0, rd_valid_o=0, rd_data_o=0, wr_v=0, clr_cnt=0. With CLR_ON_RST=0, ready_o is 1 on the first cycle after rst_n deasserts.
- Read latency: rd_en_i at edge T gives rd_valid_o=1 and data during cycle T..T+1 (RD_LAT=1), or T+1..T+2 (RD_LAT=2). Valid is a one-cycle pulse per request. Full throughput: one read per port per cycle.
- Write commit: array updated at edge T+1 for a write accepted at edge T. Back-to-back writes are allowed every cycle.
- rst_n low mid-clear or mid-read aborts all activity. Array contents are undefined unless a clear follows.
- A read in flight when clr_i is accepted is dropped; no valid pulse is produced for it.

## Structure
- Package ram_pkg holds:
  - state enum (CLEAR, READY)
  - function byte_merge(old, new, be), used for forwarding
  - RD_LAT legal-value check constant
- Sub-module ram_rd_port holds the per-port address register, forwarding merge and latency pipeline. It is generated RD_PORTS times.
- Top level holds the array, write stage, clear FSM and counter.

## Test plan
- Reset with CLR_ON_RST=1, ADDR_W=4 -> ready_o rises after exactly 16 cycles; a read of every address returns 0.
- Write 0xAA..AA at addr 3 with be=all-ones, then write 0x55 with be=0x1 at addr 3; read addr 3 on port 0 -> byte 0 is 0x55, all other bytes 0xAA.
- Write addr 5 = D1 at edge T; read addr 5 on ports 0 and 1 at edge T+1 -> both return D1, with valid at T+1 (RD_LAT=1) or T+2 (RD_LAT=2).
- Write addr 7 = D2 and read addr 7 at the same edge -> the read returns the prior value. A read at the next edge returns D2.
- Continuous reads on port 0 with clr_i pulsed mid-stream -> ready_o drops the next cycle, no further rd_valid_o pulses occur, and all addresses read 0 after ready_o returns.
- rst_n asserted while clr_cnt=8 -> all outputs return to reset values, and the clear restarts from address 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the forwarding multi-read RAM.
// No timing of its own; holds the FSM state type, the byte merge and the legal read-latency range.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One read port: samples the array word merged with the pending write, then delays it RD_LAT-1 more stages.
// Latency RD_LAT cycles, one read per cycle; flush_i drops everything in flight.
module ram_rd_port
    import ram_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 10,
    parameter int EN_W   = DATA_W / 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic              wr_v_i,
    input  logic [EN_W-1:0]   wr_be_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    logic              fwd_hit;
    logic              take;
    logic [DATA_W-1:0] merged;
    logic              v1_q;
    logic [DATA_W-1:0] d1_q;

    // The write stage holds a write the array has not committed yet.
    assign fwd_hit = wr_v_i && (wr_addr_i == rd_addr_i);
    assign take    = rd_en_i & ~flush_i;

    always_comb begin
        merged = mem_word_i;
        for (int b = 0; b < EN_W; b++) begin
            merged[b*8 +: 8] = byte_merge(mem_word_i[b*8 +: 8], wr_data_i[b*8 +: 8],
                                          fwd_hit & wr_be_i[b]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= take;
            if (take) begin
                d1_q <= merged;
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic              v2_q;
            logic [DATA_W-1:0] d2_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q & ~flush_i;
                    if (v1_q & ~flush_i) begin
                        d2_q <= d1_q;
                    end
                end
            end

            assign rd_valid_o = v2_q;
            assign rd_data_o  = d2_q;
        end else begin : g_lat1
            assign rd_valid_o = v1_q;
            assign rd_data_o  = d1_q;
        end
    endgenerate

endmodule

// File: rtl/ram_rnw1_fwd.sv
// Single-write, multi-read byte-enabled RAM with write-to-read forwarding and a zeroing clear engine.
// Writes commit one cycle after acceptance, reads return after RD_LAT; accesses are ignored while ready_o is low.
module ram_rnw1_fwd
    import ram_pkg::*;
#(
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 10,
    parameter int EN_W       = DATA_W / 8,
    parameter int RD_PORTS   = 2,
    parameter int RD_LAT     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    output logic                       ready_o,
    input  logic                       wr_en_i,
    input  logic [EN_W-1:0]            wr_be_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [RD_PORTS-1:0]        rd_en_i,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr_i,
    output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]        rd_valid_o
);

    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int RD_LAT_EFF = rd_lat_legal(RD_LAT) ? RD_LAT : RD_LAT_MIN;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rd [RD_PORTS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready_q;
    logic              accept;

    logic              wr_v_q;
    logic [EN_W-1:0]   wr_be_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // A clear request wins over any access sampled at the same edge.
    assign accept  = ready_q & ~clr_i;
    assign ready_o = ready_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            READY: begin
                if (clr_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                if (clr_i) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= (CLR_ON_RST != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            wr_v_q    <= 1'b0;
            wr_be_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == READY);
            wr_v_q    <= accept & wr_en_i;
            if (accept & wr_en_i) begin
                wr_be_q   <= wr_be_i;
                wr_addr_q <= wr_addr_i;
                wr_data_q <= wr_data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wr_v_q) begin
                for (int b = 0; b < EN_W; b++) begin
                    if (wr_be_q[b]) begin
                        mem_q[wr_addr_q][b*8 +: 8] <= wr_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
            assign mem_rd[p] = mem_q[rd_addr_i[p*ADDR_W +: ADDR_W]];

            ram_rd_port #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .EN_W   (EN_W),
                .RD_LAT (RD_LAT_EFF)
            ) u_rd_port (
                .clk        (clk),
                .rst_n      (rst_n),
                .flush_i    (~accept),
                .rd_en_i    (rd_en_i[p] & accept),
                .rd_addr_i  (rd_addr_i[p*ADDR_W +: ADDR_W]),
                .mem_word_i (mem_rd[p]),
                .wr_v_i     (wr_v_q),
                .wr_be_i    (wr_be_q),
                .wr_addr_i  (wr_addr_q),
                .wr_data_i  (wr_data_q),
                .rd_data_o  (rd_data_o[p*DATA_W +: DATA_W]),
                .rd_valid_o (rd_valid_o[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ram_rnw1_fwd.sv
// Directed and randomized bench for ram_rnw1_fwd against a word-array model with cycle-level visibility rules.
module tb_ram_rnw1_fwd;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int EN_W     = DATA_W / 8;
    localparam int RD_PORTS = 2;
    localparam int RD_LAT   = 2;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int CLR_CYC  = DEPTH;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       clr_i;
    logic                       ready_o;
    logic                       wr_en_i;
    logic [EN_W-1:0]            wr_be_i;
    logic [ADDR_W-1:0]          wr_addr_i;
    logic [DATA_W-1:0]          wr_data_i;
    logic [RD_PORTS-1:0]        rd_en_i;
    logic [RD_PORTS*ADDR_W-1:0] rd_addr_i;
    logic [RD_PORTS*DATA_W-1:0] rd_data_o;
    logic [RD_PORTS-1:0]        rd_valid_o;

    always #5 clk = ~clk;

    ram_rnw1_fwd #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .EN_W       (EN_W),
        .RD_PORTS   (RD_PORTS),
        .RD_LAT     (RD_LAT),
        .CLR_ON_RST (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr_i),
        .ready_o    (ready_o),
        .wr_en_i    (wr_en_i),
        .wr_be_i    (wr_be_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (rd_en_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int clr_start = 0;

    // Model: array contents as seen by a read sampled at the next edge.
    logic [DATA_W-1:0] model  [DEPTH];
    bit                pend_v [RD_PORTS][4];
    logic [DATA_W-1:0] pend_d [RD_PORTS][4];
    logic [DATA_W-1:0] last_d [RD_PORTS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic idle();
        clr_i     = 1'b0;
        wr_en_i   = 1'b0;
        wr_be_i   = '0;
        wr_addr_i = '0;
        wr_data_i = '0;
        rd_en_i   = '0;
        rd_addr_i = '0;
    endtask

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
        rd_en_i[p] = 1'b1;
        rd_addr_i[p*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic set_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [EN_W-1:0] be);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        wr_be_i   = be;
    endtask

    // One clock edge: predict, advance, then compare outputs 1 time unit later.
    task automatic step();
        int  e;
        bit  acc;
        int  slot;
        logic [DATA_W-1:0] obs_d;
        e   = edge_n + 1;
        acc = rst_n && !clr_i && (edge_n >= clr_start + CLR_CYC);
        for (int p = 0; p < RD_PORTS; p++) begin
            if (acc && rd_en_i[p]) begin
                slot = (e + RD_LAT - 1) % 4;
                pend_v[p][slot] = 1'b1;
                pend_d[p][slot] = model[rd_addr_i[p*ADDR_W +: ADDR_W]];
            end
        end
        if (acc && wr_en_i) begin
            for (int b = 0; b < EN_W; b++) begin
                if (wr_be_i[b]) model[wr_addr_i][b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
        end
        @(posedge clk);
        edge_n = e;
        if (!rst_n || clr_i) begin
            clr_start = e;
            for (int p = 0; p < RD_PORTS; p++)
                for (int s = 0; s < 4; s++) pend_v[p][s] = 1'b0;
            for (int a = 0; a < DEPTH; a++) model[a] = '0;
            if (!rst_n)
                for (int p = 0; p < RD_PORTS; p++) last_d[p] = '0;
        end
        #1;
        check("ready_o", 64'(ready_o), 64'(e >= clr_start + CLR_CYC));
        for (int p = 0; p < RD_PORTS; p++) begin
            slot  = e % 4;
            obs_d = rd_data_o[p*DATA_W +: DATA_W];
            check($sformatf("rd_valid_p%0d", p), 64'(rd_valid_o[p]), 64'(pend_v[p][slot]));
            if (pend_v[p][slot]) begin
                last_d[p] = pend_d[p][slot];
                pend_v[p][slot] = 1'b0;
            end
            check($sformatf("rd_data_p%0d", p), 64'(obs_d), 64'(last_d[p]));
        end
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < RD_LAT + 1; i++) step();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            idle();
            set_rd(0, ADDR_W'(a));
            set_rd(1, ADDR_W'(DEPTH - 1 - a));
            step();
        end
        drain();
    endtask

    initial begin
        for (int p = 0; p < RD_PORTS; p++) last_d[p] = '0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        idle();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst_n = 1'b1;

        // Clear after reset: traffic is ignored until ready_o rises on the 16th edge.
        for (int i = 0; i < CLR_CYC + 2; i++) begin
            idle();
            set_wr(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, '1);
            set_rd(0, ADDR_W'($urandom_range(0, DEPTH - 1)));
            step();
        end
        read_all();

        // Full write then partial byte write, read straight off the forward path.
        idle(); set_wr(4'd3, 32'hAAAA_AAAA, 4'hF); step();
        idle(); set_wr(4'd3, 32'h0000_0055, 4'h1); step();
        idle(); set_rd(0, 4'd3); step();
        drain();
        check("be_merge", 64'(rd_data_o[31:0]), 64'h0000_0000_AAAA_AA55);

        // Write then read on both ports the next edge.
        idle(); set_wr(4'd5, 32'hD1D1_0101, 4'hF); step();
        idle(); set_rd(0, 4'd5); set_rd(1, 4'd5); step();
        drain();
        check("fwd_p0", 64'(rd_data_o[31:0]), 64'h0000_0000_D1D1_0101);
        check("fwd_p1", 64'(rd_data_o[63:32]), 64'h0000_0000_D1D1_0101);

        // Same-edge read sees old data, next edge sees new data.
        idle(); set_wr(4'd7, 32'h1234_5678, 4'hF); step();
        idle(); set_wr(4'd7, 32'hD2D2_D2D2, 4'hF); set_rd(0, 4'd7); set_rd(1, 4'd7); step();
        idle(); set_rd(0, 4'd7); step();
        drain();
        check("same_edge_old", 64'(rd_data_o[63:32]), 64'h0000_0000_1234_5678);
        check("next_edge_new", 64'(rd_data_o[31:0]), 64'h0000_0000_D2D2_D2D2);

        // Randomized traffic on a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                set_wr(ADDR_W'($urandom_range(0, 5)), $urandom, EN_W'($urandom));
            for (int p = 0; p < RD_PORTS; p++)
                if ($urandom_range(0, 2) != 0) set_rd(p, ADDR_W'($urandom_range(0, 5)));
            step();
        end
        drain();
        read_all();

        // Clear pulse in the middle of a continuous read stream.
        for (int i = 0; i < 30; i++) begin
            idle();
            set_rd(0, ADDR_W'($urandom_range(0, DEPTH - 1)));
            if (i < 10) set_wr(ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom, '1);
            clr_i = (i == 8);
            step();
        end
        read_all();

        // Reset while the clear engine is halfway through.
        idle(); set_wr(4'd9, 32'hCAFE_F00D, 4'hF); step();
        idle(); clr_i = 1'b1; step();
        idle();
        for (int i = 0; i < 8; i++) step();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) step();
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_valid", 64'(rd_valid_o), 64'd0);
        check("rst_data", 64'(rd_data_o), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < CLR_CYC + 2; i++) step();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
